// File: rtl/tanh_arbiter.sv
// tanh_arbiter: round-robin scheduler sharing one iterative tanh unit among NREQ requesters.
// Grants one request at a time, sequences the unit's hold/ack/clear handshake and returns the
// result tagged with the requester id.
// Optional feature macro: TANH_TIMEOUT_EN bounds the WAIT state to TO_CYC cycles; on expiry the
// unit is flushed and a response with timeout_err=1 and rsp_data=0 is returned.
module tanh_arbiter #(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned IDW    = 2,
    parameter int unsigned DW     = 32,
    parameter int unsigned TO_CYC = 31
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*DW-1:0]  req_data,
    output logic [NREQ-1:0]     req_ready,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [IDW-1:0]      rsp_id,
    output logic [DW-1:0]       rsp_data,
    output logic                timeout_err,
    output logic                busy,
    output logic [DW-1:0]       tu_ox,
    output logic                tu_wa,
    output logic                tu_comp,
    output logic                tu_locked,
    input  logic                tu_en,
    input  logic [DW-1:0]       tu_tanh
);

    typedef enum logic [2:0] {StIdle, StLaunch, StWait, StAck, StRsp, StFlush} state_e;

    state_e            state_q, state_d;
    logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [NREQ-1:0]   req_ready_q, req_ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]    rsp_id_q, rsp_id_d;
    logic [DW-1:0]     rsp_data_q, rsp_data_d;
    logic [DW-1:0]     tu_ox_q, tu_ox_d;
    logic              tu_wa_q, tu_wa_d;
    logic              tu_comp_q, tu_comp_d;
    logic              tu_locked_q, tu_locked_d;
    logic              busy_q, busy_d;

    logic [IDW-1:0]    grant, grant_hi, grant_lo;
    logic              found_hi;

`ifdef TANH_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TO_CYC + 1);
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              to_err_q, to_err_d;
`else
    // TO_CYC only matters when the timeout is built in.
    logic              unused_to_cyc;
    assign unused_to_cyc = ^TO_CYC;
`endif

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = busy_q;
    assign tu_ox     = tu_ox_q;
    assign tu_wa     = tu_wa_q;
    assign tu_comp   = tu_comp_q;
    assign tu_locked = tu_locked_q;
`ifdef TANH_TIMEOUT_EN
    assign timeout_err = to_err_q;
`else
    assign timeout_err = 1'b0;
`endif

    // Round-robin pick: lowest requester above rr_ptr, otherwise lowest requester overall.
    always_comb begin
        grant_hi = '0;
        grant_lo = '0;
        found_hi = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                grant_lo = IDW'(i);
                if (i > int'(rr_ptr_q)) begin
                    grant_hi = IDW'(i);
                    found_hi = 1'b1;
                end
            end
        end
        grant = found_hi ? grant_hi : grant_lo;
    end

    // Next-state and next-output logic; every output is registered from these _d values.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        req_ready_d = '0;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        tu_ox_d     = tu_ox_q;
`ifdef TANH_TIMEOUT_EN
        cnt_d       = cnt_q;
        to_err_d    = to_err_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (|req_valid) begin
                    state_d  = StLaunch;
                    rr_ptr_d = grant;
                    rsp_id_d = grant;
                    for (int i = 0; i < NREQ; i++) begin
                        if (grant == IDW'(i)) begin
                            req_ready_d[i] = 1'b1;
                            tu_ox_d        = req_data[i*DW +: DW];
                        end
                    end
                end
            end
            StLaunch: begin
                state_d = StWait;
`ifdef TANH_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            StWait: begin
                if (tu_en) begin
                    rsp_data_d  = tu_tanh;
                    rsp_valid_d = 1'b1;
                    state_d     = StAck;
                end
`ifdef TANH_TIMEOUT_EN
                else if (cnt_q == CW'(TO_CYC - 1)) begin
                    state_d    = StFlush;
                    rsp_data_d = '0;
                    to_err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            StAck: begin
                state_d = StRsp;
                // rsp_valid is already visible here, so a ready consumer completes the
                // handshake now rather than seeing the same result twice.
                if (rsp_ready) rsp_valid_d = 1'b0;
            end
            StRsp: begin
                if (rsp_ready || !rsp_valid_q) begin
                    rsp_valid_d = 1'b0;
                    state_d     = StIdle;
`ifdef TANH_TIMEOUT_EN
                    to_err_d    = 1'b0;
`endif
                end
            end
            StFlush: begin
                state_d     = StRsp;
                rsp_valid_d = 1'b1;
            end
            default: state_d = StIdle;
        endcase

        // Unit controls and busy follow the state being entered.
        tu_wa_d     = (state_d != StLaunch);
        tu_comp_d   = (state_d == StAck);
        tu_locked_d = (state_d == StFlush);
        busy_d      = (state_d != StIdle);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            rr_ptr_q    <= IDW'(NREQ - 1);
            req_ready_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
            tu_ox_q     <= '0;
            tu_wa_q     <= 1'b1;
            tu_comp_q   <= 1'b0;
            tu_locked_q <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
            tu_ox_q     <= tu_ox_d;
            tu_wa_q     <= tu_wa_d;
            tu_comp_q   <= tu_comp_d;
            tu_locked_q <= tu_locked_d;
            busy_q      <= busy_d;
        end
    end

`ifdef TANH_TIMEOUT_EN
    // WAIT cycle counter and timeout flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            to_err_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            to_err_q <= to_err_d;
        end
    end
`endif

endmodule

// File: tb/tb_tanh_arbiter.sv
// tb_tanh_arbiter: directed bench for tanh_arbiter with a behavioural iterative tanh unit.
module tb_tanh_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int DW   = 32;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*DW-1:0]  req_data;
    logic [NREQ-1:0]     req_ready;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [IDW-1:0]      rsp_id;
    logic [DW-1:0]       rsp_data;
    logic                timeout_err;
    logic                busy;
    logic [DW-1:0]       tu_ox;
    logic                tu_wa;
    logic                tu_comp;
    logic                tu_locked;
    logic                tu_en = 1'b0;
    logic [DW-1:0]       tu_tanh = '0;

    int n_vec = 0;
    int n_err = 0;

    tanh_arbiter #(
        .NREQ   (NREQ),
        .IDW    (IDW),
        .DW     (DW),
        .TO_CYC (31)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_data    (rsp_data),
        .timeout_err (timeout_err),
        .busy        (busy),
        .tu_ox       (tu_ox),
        .tu_wa       (tu_wa),
        .tu_comp     (tu_comp),
        .tu_locked   (tu_locked),
        .tu_en       (tu_en),
        .tu_tanh     (tu_tanh)
    );

    always #5 clk = ~clk;

    // Behavioural tanh unit: starts when hold drops, raises en after a fixed latency,
    // drops en on comp, cleared by locked. en_kill models a unit that never answers.
    logic        u_run   = 1'b0;
    int          u_cnt   = 0;
    logic [31:0] u_op    = '0;
    logic        en_kill = 1'b0;

    function automatic logic [31:0] tanh_ref(input logic [31:0] x);
        case (x)
            32'h0200_0000: return 32'h01D9_3A70;
            32'h0800_0000: return 32'h0400_0000;
            32'hF800_0000: return 32'hFC00_0000;
            default:       return x ^ 32'h5A5A_5A5A;
        endcase
    endfunction

    always @(posedge clk) begin
        if (tu_locked) begin
            u_run <= 1'b0;
            tu_en <= 1'b0;
        end else if (tu_en) begin
            if (tu_comp) tu_en <= 1'b0;
        end else if (u_run) begin
            if (u_cnt <= 1) begin
                u_run   <= 1'b0;
                tu_en   <= !en_kill;
                tu_tanh <= tanh_ref(u_op);
            end else begin
                u_cnt <= u_cnt - 1;
            end
        end else if (!tu_wa) begin
            u_run <= 1'b1;
            u_op  <= tu_ox;
            u_cnt <= (tu_ox == 32'h0800_0000 || tu_ox == 32'hF800_0000) ? 5 : 14;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant();
        for (int t = 0; t < 50 && req_ready == '0; t++) tick();
    endtask

    task automatic wait_rsp();
        for (int t = 0; t < 60 && !rsp_valid; t++) tick();
    endtask

    task automatic run_op(input int id, input logic [31:0] op, input logic [31:0] exp);
        logic [3:0] oh;
        oh = 4'b0001 << id;
        req_data[id*DW +: DW] = op;
        req_valid[id] = 1'b1;
        wait_grant();
        check("op_grant", {60'd0, req_ready}, {60'd0, oh});
        check("op_tu_ox", {32'd0, tu_ox}, {32'd0, op});
        req_valid[id] = 1'b0;
        wait_rsp();
        check("op_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        check("op_rsp_id", {62'd0, rsp_id}, 64'(id));
        check("op_rsp_data", {32'd0, rsp_data}, {32'd0, exp});
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("op_rsp_done", {63'd0, rsp_valid}, 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          bad;
        int          n;
        logic [3:0]  oh;
        logic [31:0] ev;

        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        rsp_ready = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_req_ready", {60'd0, req_ready}, 64'd0);
        check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("rst_rsp_id", {62'd0, rsp_id}, 64'd0);
        check("rst_rsp_data", {32'd0, rsp_data}, 64'd0);
        check("rst_timeout_err", {63'd0, timeout_err}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_tu_ox", {32'd0, tu_ox}, 64'd0);
        check("rst_tu_wa", {63'd0, tu_wa}, 64'd1);
        check("rst_tu_comp", {63'd0, tu_comp}, 64'd0);
        check("rst_tu_locked", {63'd0, tu_locked}, 64'd1);
        rst = 1'b0;
        tick();
        check("locked_clears", {63'd0, tu_locked}, 64'd0);

        // Single op, requester 0, tanh(0.5)
        req_data[31:0] = 32'h0200_0000;
        req_valid      = 4'b0001;
        tick();
        check("t1_grant", {60'd0, req_ready}, 64'h1);
        check("t1_busy", {63'd0, busy}, 64'd1);
        check("t1_launch_wa", {63'd0, tu_wa}, 64'd0);
        check("t1_tu_ox", {32'd0, tu_ox}, 64'h0200_0000);
        req_valid = '0;
        tick();
        check("t1_ready_pulse", {60'd0, req_ready}, 64'd0);
        check("t1_wait_wa", {63'd0, tu_wa}, 64'd1);
        for (int t = 0; t < 60 && !tu_comp; t++) tick();
        check("t1_comp", {63'd0, tu_comp}, 64'd1);
        check("t1_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        check("t1_rsp_id", {62'd0, rsp_id}, 64'd0);
        check("t1_rsp_data", {32'd0, rsp_data}, 64'h01D9_3A70);
        tick();
        check("t1_comp_pulse", {63'd0, tu_comp}, 64'd0);
        check("t1_rsp_hold", {63'd0, rsp_valid}, 64'd1);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("t1_rsp_done", {63'd0, rsp_valid}, 64'd0);
        check("t1_idle", {63'd0, busy}, 64'd0);

        // Saturation on requester 2
        run_op(2, 32'h0800_0000, 32'h0400_0000);
        run_op(2, 32'hF800_0000, 32'hFC00_0000);

        // Backpressure: result held, competing request not accepted
        req_data[1*DW +: DW] = 32'h0010_0000;
        req_valid[1] = 1'b1;
        wait_grant();
        check("bp_grant", {60'd0, req_ready}, 64'h2);
        req_valid[1] = 1'b0;
        wait_rsp();
        req_data[3*DW +: DW] = 32'h0030_0000;
        req_valid[3] = 1'b1;
        bad = 0;
        for (int t = 0; t < 10; t++) begin
            tick();
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== 32'h5A4A_5A5A ||
                req_ready !== 4'b0000) bad++;
        end
        check("bp_hold", 64'(bad), 64'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("bp_released", {63'd0, rsp_valid}, 64'd0);
        check("bp_no_early_grant", {60'd0, req_ready}, 64'd0);
        tick();
        check("bp_next_grant", {60'd0, req_ready}, 64'h8);
        req_valid[3] = 1'b0;
        wait_rsp();
        check("bp_rsp3_data", {32'd0, rsp_data}, 64'h5A6A_5A5A);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;

        // Reset during WAIT: result lost, unit cleared
        req_data[1*DW +: DW] = 32'h0010_0000;
        req_valid[1] = 1'b1;
        wait_grant();
        req_valid[1] = 1'b0;
        for (int t = 0; t < 4; t++) tick();
        check("r5_busy_wait", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        tick();
        check("r5_locked", {63'd0, tu_locked}, 64'd1);
        check("r5_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("r5_busy", {63'd0, busy}, 64'd0);
        rst = 1'b0;
        bad = 0;
        for (int t = 0; t < 20; t++) begin
            tick();
            if (rsp_valid !== 1'b0 || busy !== 1'b0) bad++;
        end
        check("r5_quiet", 64'(bad), 64'd0);

        // Fairness: all requesters held, expect 0,1,2,3,0
        for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = 32'((i + 1) << 16);
        rsp_ready = 1'b1;
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            oh = 4'b0001 << (k % 4);
            ev = 32'(((k % 4) + 1) << 16) ^ 32'h5A5A_5A5A;
            wait_grant();
            check("rr_grant", {60'd0, req_ready}, {60'd0, oh});
            tick();
            check("rr_pulse", {60'd0, req_ready}, 64'd0);
            wait_rsp();
            check("rr_id", {62'd0, rsp_id}, 64'(k % 4));
            check("rr_data", {32'd0, rsp_data}, {32'd0, ev});
            if (k == 4) req_valid = '0;
            tick();
        end
        tick();
        rsp_ready = 1'b0;
        check("rr_idle", {63'd0, busy}, 64'd0);

        // Unit that never answers
        en_kill = 1'b1;
        req_data[31:0] = 32'h0000_1234;
        req_valid[0] = 1'b1;
        wait_grant();
        req_valid[0] = 1'b0;
`ifdef TANH_TIMEOUT_EN
        n = 0;
        for (int t = 0; t < 80 && !tu_locked; t++) begin
            tick();
            n++;
        end
        check("to_locked", {63'd0, tu_locked}, 64'd1);
        check("to_cycles", 64'(n), 64'd32);
        tick();
        check("to_locked_pulse", {63'd0, tu_locked}, 64'd0);
        check("to_rsp_valid", {63'd0, rsp_valid}, 64'd1);
        check("to_err", {63'd0, timeout_err}, 64'd1);
        check("to_rsp_data", {32'd0, rsp_data}, 64'd0);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("to_err_clear", {63'd0, timeout_err}, 64'd0);
        check("to_rsp_done", {63'd0, rsp_valid}, 64'd0);
`else
        n = 0;
        for (int t = 0; t < 60; t++) tick();
        check("nt_busy", {63'd0, busy}, 64'd1);
        check("nt_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("nt_err", {63'd0, timeout_err}, 64'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("nt_recovered", {63'd0, busy}, 64'(n));
`endif
        en_kill = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
